// File: rtl/reg_file_io.sv
// reg_file_io: general register file with NPORT memory-mapped I/O channels at the
// top addresses; one write port, two combinational read ports.

module reg_file_io_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_pin,
  input  logic             i_lat_we,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_dir_we,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_lat,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_dir,
  output logic             o_chg
);
  logic [WIDTH-1:0] r_sync1, r_sync2, r_samp, r_lat;
  logic             r_dir, r_dir_q, r_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_samp  <= '0;
      r_lat   <= '0;
      r_dir   <= 1'b0;
      r_dir_q <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_dir_q <= r_dir;
      if (i_dir_we) r_dir <= i_dir;
      if (i_lat_we) r_lat <= i_wdata;
      if (!r_dir)   r_samp <= r_sync2;
      // r_dir_q masks the stale-sample difference right after output->input
      r_chg <= !r_dir && !r_dir_q && (r_sync2 != r_samp);
    end
  end

  assign o_lat = r_lat;
  assign o_rd  = r_dir ? r_lat : r_samp;
  assign o_dir = r_dir;
  assign o_chg = r_chg;
endmodule

module reg_file_io #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NPORT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr_a,
  input  logic [$clog2(DEPTH)-1:0]   raddr_b,
  output logic [WIDTH-1:0]           rdata_a,
  output logic [WIDTH-1:0]           rdata_b,
  input  logic                       dir_we,
  input  logic [NPORT-1:0]           dir_wdata,
  input  logic [NPORT*WIDTH-1:0]     port_in,
  output logic [NPORT*WIDTH-1:0]     port_out,
  output logic [NPORT-1:0]           port_oe,
  output logic [NPORT-1:0]           port_chg
);
  localparam int AW  = $clog2(DEPTH);
  localparam int GPR = DEPTH - NPORT;

  logic [GPR-1:0][WIDTH-1:0]   r_gpr;
  logic [NPORT-1:0][WIDTH-1:0] w_lat, w_ch_rd;
  logic [NPORT-1:0]            w_lat_we;

  // addresses >= DEPTH match no slot, so such writes are dropped
  always_ff @(posedge clk) begin
    if (rst) r_gpr <= '0;
    else if (we)
      for (int i = 0; i < GPR; i++)
        if (waddr == AW'(i)) r_gpr[i] <= wdata;
  end

  for (genvar k = 0; k < NPORT; k++) begin : g_ch
    assign w_lat_we[k] = we && (waddr == AW'(GPR + k));
    reg_file_io_ch #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_pin    (port_in[k*WIDTH +: WIDTH]),
      .i_lat_we (w_lat_we[k]),
      .i_wdata  (wdata),
      .i_dir_we (dir_we),
      .i_dir    (dir_wdata[k]),
      .o_lat    (w_lat[k]),
      .o_rd     (w_ch_rd[k]),
      .o_dir    (port_oe[k]),
      .o_chg    (port_chg[k])
    );
  end

  assign port_out = w_lat;

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < GPR; i++) begin
      if (raddr_a == AW'(i)) rdata_a = r_gpr[i];
      if (raddr_b == AW'(i)) rdata_b = r_gpr[i];
    end
    for (int k = 0; k < NPORT; k++) begin
      if (raddr_a == AW'(GPR + k)) rdata_a = w_ch_rd[k];
      if (raddr_b == AW'(GPR + k)) rdata_b = w_ch_rd[k];
    end
  end
endmodule

// File: tb/tb_reg_file_io.sv
// Scoreboard bench for reg_file_io: default instance plus a DEPTH=10 instance
// sharing all inputs for the out-of-range address case.

module tb_reg_file_io;
  localparam int W = 8, D = 16, NP = 2, AW = 4, GPR = D - NP;

  logic clk = 1'b0;
  logic rst, we, dir_we;
  logic [AW-1:0]    waddr, raddr_a, raddr_b;
  logic [W-1:0]     wdata, rdata_a, rdata_b, rd10_a, rd10_b;
  logic [NP-1:0]    dir_wdata, port_oe, port_chg, oe10, chg10;
  logic [NP*W-1:0]  port_in, port_out, out10;

  always #5 clk = ~clk;

  reg_file_io #(.WIDTH(W), .DEPTH(D), .NPORT(NP)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .dir_we(dir_we), .dir_wdata(dir_wdata), .port_in(port_in),
    .port_out(port_out), .port_oe(port_oe), .port_chg(port_chg));

  reg_file_io #(.WIDTH(W), .DEPTH(10), .NPORT(NP)) u10 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd10_a), .rdata_b(rd10_b),
    .dir_we(dir_we), .dir_wdata(dir_wdata), .port_in(port_in),
    .port_out(out10), .port_oe(oe10), .port_chg(chg10));

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m [GPR];
  logic [W-1:0] m10 [8];
  logic [W-1:0] tog, first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got %0h expected none", got);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input string ta, input logic [31:0] ea,
                     input string tgb, input logic [31:0] eb);
    raddr_a = a;
    raddr_b = b;
    sb_push(ta, ea);
    sb_push(tgb, eb);
    #1;
    sb_pop(rdata_a);
    sb_pop(rdata_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; we = 0; dir_we = 0; waddr = 0; wdata = 0;
    raddr_a = 0; raddr_b = 0; dir_wdata = 0; port_in = 0;
    tick(); tick();
    rst = 0;

    // reset state
    rd2(3, AW'(GPR), "rst_r3", 0, "rst_ch0", 0);
    sb_push("rst_oe", 0); sb_push("rst_out", 0); sb_push("rst_chg", 0);
    sb_pop(port_oe); sb_pop(port_out); sb_pop(port_chg);

    // write 0xA5 to addr 3: invisible in write cycle, visible next cycle
    we = 1; waddr = 3; wdata = 8'hA5;
    rd2(3, 3, "wcyc_a", 0, "wcyc_b", 0);
    tick(); we = 0;
    rd2(3, 3, "wnext_a", 8'hA5, "wnext_b", 8'hA5);

    // random fill of every general register, read back crosswise
    for (int i = 0; i < GPR; i++) begin
      m[i] = W'($urandom_range(0, 255));
      we = 1; waddr = AW'(i); wdata = m[i];
      tick();
    end
    we = 0;
    for (int i = 0; i < GPR; i++)
      rd2(AW'(i), AW'(GPR-1-i), "gpr_a", m[i], "gpr_b", m[GPR-1-i]);

    // input channel 0: 3-edge latency, one-cycle change pulse
    raddr_a = AW'(GPR);
    port_in[7:0] = 8'h3C;
    for (int e = 1; e <= 4; e++) begin
      tick();
      sb_push("in_samp", (e >= 3) ? 32'h3C : 32'h0);
      sb_push("in_chg", (e == 3) ? 32'h1 : 32'h0);
      sb_pop(rdata_a);
      sb_pop(port_chg);
    end

    // output mode on ch0 with same-cycle latch write
    dir_we = 1; dir_wdata = 2'b01; we = 1; waddr = AW'(GPR); wdata = 8'h77;
    tick(); dir_we = 0; we = 0;
    sb_push("out_lat", 8'h77); sb_push("out_oe", 2'b01); sb_push("out_rd", 8'h77);
    sb_pop(port_out[7:0]); sb_pop(port_oe); sb_pop(rdata_a);
    port_in[7:0] = 8'h11;
    for (int e = 0; e < 4; e++) begin
      tick();
      sb_push("out_nochg", 0); sb_push("out_rd_hold", 8'h77);
      sb_pop(port_chg); sb_pop(rdata_a);
    end

    // back to input: sample reloads without a pulse
    dir_we = 1; dir_wdata = 2'b00;
    tick(); dir_we = 0;
    sb_push("o2i_held", 8'h3C); sb_push("o2i_chg0", 0);
    sb_pop(rdata_a); sb_pop(port_chg);
    tick();
    sb_push("o2i_load", 8'h11); sb_push("o2i_chg1", 0);
    sb_pop(rdata_a); sb_pop(port_chg);
    tick();
    sb_push("o2i_chg2", 0); sb_pop(port_chg);

    // reset wins over same-cycle we and dir_we
    we = 1; waddr = 2; wdata = 8'hFF; dir_we = 1; dir_wdata = 2'b11; rst = 1;
    tick(); we = 0; dir_we = 0; rst = 0;
    rd2(2, AW'(GPR), "rc_r2", 0, "rc_ch0", 0);
    rd2(3, AW'(GPR+1), "rc_r3", 0, "rc_ch1", 0);
    sb_push("rc_oe", 0); sb_push("rc_out", 0); sb_push("rc_chg", 0);
    sb_pop(port_oe); sb_pop(port_out); sb_pop(port_chg);
    raddr_a = AW'(GPR);
    for (int e = 1; e <= 3; e++) begin
      tick();
      sb_push("rc_post_chg", (e == 3) ? 32'h1 : 32'h0);
      sb_push("rc_post_samp", (e == 3) ? 32'h11 : 32'h0);
      sb_pop(port_chg); sb_pop(rdata_a);
    end

    // mid-stream reset while ch1 toggles
    raddr_b = AW'(GPR+1);
    tog = 8'h55;
    for (int c = 0; c < 10; c++) begin
      tog = ~tog;
      port_in[15:8] = tog;
      rst = (c == 5);
      if (c == 6) first = tog;
      tick();
      if (c >= 5 && c <= 7) begin
        sb_push("mr_chg", 0); sb_push("mr_samp", 0);
        sb_pop(port_chg); sb_pop(rdata_b);
      end
      if (c == 8) begin
        sb_push("mr_chg_on", 2'b11); sb_push("mr_samp_on", first);
        sb_pop(port_chg); sb_pop(rdata_b);
      end
    end
    rst = 0;

    // DEPTH=10: write to addr 12 changes nothing, reads beyond DEPTH give 0
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 8; i++) begin
      m10[i] = W'($urandom_range(0, 255));
      we = 1; waddr = AW'(i); wdata = m10[i];
      tick();
    end
    waddr = 8; wdata = 8'h66; tick();
    waddr = 9; wdata = 8'h99; tick();
    waddr = 12; wdata = 8'hEE; tick();
    we = 0;
    sb_push("d10_out", 16'h9966); sb_push("d10_oe", 0);
    sb_pop(out10); sb_pop(oe10);
    for (int i = 0; i < 8; i++) begin
      raddr_a = AW'(i);
      sb_push("d10_gpr", m10[i]);
      #1;
      sb_pop(rd10_a);
    end
    raddr_a = 12; raddr_b = 10;
    sb_push("d10_rd12", 0); sb_push("d10_rd10", 0);
    #1;
    sb_pop(rd10_a); sb_pop(rd10_b);

    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
